// File: rtl/edge_event_arbiter.sv
// Holds per-channel rising/falling edge pulses as pending events and hands
// them one at a time to a single valid/ready consumer in round-robin order.
module edge_event_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int IDXWIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] pos_pulse,
    input  logic [NUM_INPUTS-1:0] neg_pulse,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IDXWIDTH-1:0]   evt_index,
    output logic                  evt_rising,
    output logic [NUM_INPUTS-1:0] overflow,
    input  logic                  overflow_clr
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_INPUTS-1:0] r_pend_r;
    logic [NUM_INPUTS-1:0] r_pend_f;
    logic [NUM_INPUTS-1:0] r_rise_first;
    logic [NUM_INPUTS-1:0] r_overflow;
    logic [IDXWIDTH-1:0]   r_rr;
    logic                  r_evt_valid;
    logic [IDXWIDTH-1:0]   r_evt_index;
    logic                  r_evt_rising;

    logic [NUM_INPUTS-1:0] w_pend_any;
    logic                  w_found;
    logic [IDXWIDTH-1:0]   w_sel;
    logic [IDXWIDTH-1:0]   w_cand;
    logic                  w_grant;
    logic                  w_sel_rising;
    logic [NUM_INPUTS-1:0] w_clr_r;
    logic [NUM_INPUTS-1:0] w_clr_f;
    logic [NUM_INPUTS-1:0] w_keep_r;
    logic [NUM_INPUTS-1:0] w_keep_f;
    logic [NUM_INPUTS-1:0] w_pend_r_nxt;
    logic [NUM_INPUTS-1:0] w_pend_f_nxt;
    logic [NUM_INPUTS-1:0] w_rise_first_nxt;
    logic [NUM_INPUTS-1:0] w_ovf_new;
    logic [NUM_INPUTS-1:0] w_ovf_nxt;

    // Channel number base+k, wrapping at NUM_INPUTS.
    function automatic logic [IDXWIDTH-1:0] wrap_add(input logic [IDXWIDTH-1:0] base, input int k);
        int v_sum;
        v_sum = (int'(base) + k) % NUM_INPUTS;
        return v_sum[IDXWIDTH-1:0];
    endfunction

    assign w_pend_any = r_pend_r | r_pend_f;

    // Round-robin search: first pending channel after the last granted one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = {IDXWIDTH{1'b0}};
        w_cand  = {IDXWIDTH{1'b0}};
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            w_cand = wrap_add(r_rr, k);
            if (!w_found && w_pend_any[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_grant      = (r_state == ST_IDLE) && w_found;
    assign w_sel_rising = r_pend_r[w_sel] & (~r_pend_f[w_sel] | r_rise_first[w_sel]);

    // Which pending bit the scheduler retires this cycle.
    always_comb begin
        w_clr_r = {NUM_INPUTS{1'b0}};
        w_clr_f = {NUM_INPUTS{1'b0}};
        if (w_grant) begin
            if (w_sel_rising) begin
                w_clr_r[w_sel] = 1'b1;
            end else begin
                w_clr_f[w_sel] = 1'b1;
            end
        end else begin
            w_clr_r = {NUM_INPUTS{1'b0}};
        end
    end

    // A pulse landing on a bit being retired re-arms it rather than overflowing.
    assign w_keep_r     = r_pend_r & ~w_clr_r;
    assign w_keep_f     = r_pend_f & ~w_clr_f;
    assign w_pend_r_nxt = w_keep_r | pos_pulse;
    assign w_pend_f_nxt = w_keep_f | neg_pulse;
    assign w_ovf_new    = (pos_pulse & w_keep_r) | (neg_pulse & w_keep_f);
    assign w_ovf_nxt    = (overflow_clr ? {NUM_INPUTS{1'b0}} : r_overflow) | w_ovf_new;

    // Order bit: records which edge arrived first when both end up pending.
    always_comb begin
        w_rise_first_nxt = r_rise_first;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (pos_pulse[i] && neg_pulse[i]) begin
                w_rise_first_nxt[i] = 1'b1;
            end else if (pos_pulse[i] && !w_keep_f[i]) begin
                w_rise_first_nxt[i] = 1'b1;
            end else if (neg_pulse[i] && !w_keep_r[i]) begin
                w_rise_first_nxt[i] = 1'b0;
            end else begin
                w_rise_first_nxt[i] = r_rise_first[i];
            end
        end
    end

    // Pending store and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_r     <= {NUM_INPUTS{1'b0}};
            r_pend_f     <= {NUM_INPUTS{1'b0}};
            r_rise_first <= {NUM_INPUTS{1'b0}};
            r_overflow   <= {NUM_INPUTS{1'b0}};
        end else begin
            r_pend_r     <= w_pend_r_nxt;
            r_pend_f     <= w_pend_f_nxt;
            r_rise_first <= w_rise_first_nxt;
            r_overflow   <= w_ovf_nxt;
        end
    end

    // Delivery FSM with registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_index  <= {IDXWIDTH{1'b0}};
            r_evt_rising <= 1'b0;
            r_rr         <= IDXWIDTH'(NUM_INPUTS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_evt_index  <= w_sel;
                        r_evt_rising <= w_sel_rising;
                        r_rr         <= w_sel;
                        r_evt_valid  <= 1'b1;
                        r_state      <= ST_PRESENT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    if (r_evt_valid && evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_PRESENT;
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_index  = r_evt_index;
    assign evt_rising = r_evt_rising;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (NUM_INPUTS=4).
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] pos_pulse;
    logic [3:0] neg_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_index;
    logic       evt_rising;
    logic [3:0] overflow;
    logic       overflow_clr;

    int checks;
    int errors;

    edge_event_arbiter #(.NUM_INPUTS(4), .IDXWIDTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pos_pulse    (pos_pulse),
        .neg_pulse    (neg_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_index    (evt_index),
        .evt_rising   (evt_rising),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        pos_pulse    = 4'b0000;
        neg_pulse    = 4'b0000;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {evt_valid, evt_index, evt_rising});
        end
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0000", overflow);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 0", evt_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        pos_pulse = 4'b0100;
        tick();
        pos_pulse = 4'b0000;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early got %b want 0", evt_valid);
        end
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1101) begin
            errors++;
            $display("FAIL single_event got %b want 1101", {evt_valid, evt_index, evt_rising});
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop got %b want 0", evt_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            pos_pulse = 4'b1111;
            tick();
            pos_pulse = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if ({evt_valid, evt_index, evt_rising} !== {1'b1, 2'(k), 1'b1}) begin
                    errors++;
                    $display("FAIL rr_event rep %0d k %0d got %b want %b", rep, k,
                             {evt_valid, evt_index, evt_rising}, {1'b1, 2'(k), 1'b1});
                end
                tick();
                checks++;
                if (evt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_gap rep %0d k %0d got %b want 0", rep, k, evt_valid);
                end
            end
        end
    endtask

    task automatic test_ordering();
        do_reset();
        evt_ready = 1'b0;
        neg_pulse = 4'b0010;
        tick();
        neg_pulse = 4'b0000;
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1010) begin
            errors++;
            $display("FAIL order_fall got %b want 1010", {evt_valid, evt_index, evt_rising});
        end
        pos_pulse = 4'b0010;
        tick();
        pos_pulse = 4'b0000;
        tick();
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1010) begin
            errors++;
            $display("FAIL order_hold got %b want 1010", {evt_valid, evt_index, evt_rising});
        end
        evt_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1011) begin
            errors++;
            $display("FAIL order_rise got %b want 1011", {evt_valid, evt_index, evt_rising});
        end
        tick();
        evt_ready = 1'b0;
        pos_pulse = 4'b0100;
        neg_pulse = 4'b0100;
        tick();
        pos_pulse = 4'b0000;
        neg_pulse = 4'b0000;
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1101) begin
            errors++;
            $display("FAIL order_both_rise got %b want 1101", {evt_valid, evt_index, evt_rising});
        end
        evt_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1100) begin
            errors++;
            $display("FAIL order_both_fall got %b want 1100", {evt_valid, evt_index, evt_rising});
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        pos_pulse = 4'b0001;
        tick();
        pos_pulse = 4'b0000;
        tick();
        pos_pulse = 4'b1000;
        tick();
        pos_pulse = 4'b0000;
        tick();
        pos_pulse = 4'b1000;
        tick();
        pos_pulse = 4'b0000;
        checks++;
        if (overflow !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_set got %b want 1000", overflow);
        end
        evt_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising} !== 4'b1111) begin
            errors++;
            $display("FAIL ovf_event got %b want 1111", {evt_valid, evt_index, evt_rising});
        end
        tick();
        tick();
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_single got %b want 0", evt_valid);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clr got %b want 0000", overflow);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        evt_ready = 1'b1;
        pos_pulse = 4'b0010;
        tick();
        tick();
        pos_pulse = 4'b0000;
        checks++;
        if ({evt_valid, evt_index, evt_rising, overflow} !== 8'b1011_0000) begin
            errors++;
            $display("FAIL coll_first got %b want 10110000", {evt_valid, evt_index, evt_rising, overflow});
        end
        tick();
        tick();
        checks++;
        if ({evt_valid, evt_index, evt_rising, overflow} !== 8'b1011_0000) begin
            errors++;
            $display("FAIL coll_second got %b want 10110000", {evt_valid, evt_index, evt_rising, overflow});
        end
        tick();
        evt_ready = 1'b0;
        pos_pulse = 4'b0001;
        tick();
        pos_pulse = 4'b0000;
        tick();
        pos_pulse = 4'b0100;
        tick();
        tick();
        pos_pulse = 4'b0000;
        checks++;
        if (overflow !== 4'b0100) begin
            errors++;
            $display("FAIL coll_ovf got %b want 0100", overflow);
        end
        pos_pulse    = 4'b0100;
        overflow_clr = 1'b1;
        tick();
        pos_pulse    = 4'b0000;
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0100) begin
            errors++;
            $display("FAIL coll_clr_same got %b want 0100", overflow);
        end
        pos_pulse = 4'b1000;
        tick();
        overflow_clr = 1'b1;
        tick();
        pos_pulse    = 4'b0000;
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 4'b1000) begin
            errors++;
            $display("FAIL coll_clr_other got %b want 1000", overflow);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        pos_pulse = 4'b0001;
        tick();
        pos_pulse = 4'b1000;
        tick();
        tick();
        pos_pulse = 4'b0000;
        checks++;
        if ({evt_valid, overflow} !== 5'b1_1000) begin
            errors++;
            $display("FAIL rstmid_pre got %b want 11000", {evt_valid, overflow});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_index, evt_rising, overflow} !== 8'b0000_0000) begin
            errors++;
            $display("FAIL rstmid_async got %b want 00000000", {evt_valid, evt_index, evt_rising, overflow});
        end
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (evt_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_flushed got %0d events want 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_ordering();
        test_overflow();
        test_collisions();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
